// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, pause/resume and optional auto-reload.
// Raises a one-cycle expired pulse at each terminal tick; done stays high until the next load.
`timescale 1ns/1ps

module countdown_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             toggle,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] timer,
   output logic             running,
   output logic             expired,
   output logic             done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PCNT_ONE  = PW'(1'b1);
   localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] timer_q, timer_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             expired_d;
   logic             running_q, expired_q, done_q;

   // Next state: load beats toggle, toggle beats the prescaler tick.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      reload_d  = reload_q;
      pcnt_d    = pcnt_q;
      expired_d = 1'b0;
      if (load) begin
         timer_d  = load_value;
         reload_d = load_value;
         pcnt_d   = {PW{1'b0}};
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (toggle && (timer_q != CNT_ZERO)) begin
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (toggle) begin
                  state_d = PAUSE;
               end else if (pcnt_q == PCNT_LAST) begin
                  pcnt_d = {PW{1'b0}};
                  if (timer_q > CNT_ONE) begin
                     timer_d = timer_q - CNT_ONE;
                  end else begin
                     // Terminal tick; a zero reload value would leave RUN with nothing to count.
                     expired_d = 1'b1;
                     if (auto_reload && (reload_q != CNT_ZERO)) begin
                        timer_d = reload_q;
                     end else begin
                        timer_d = CNT_ZERO;
                        state_d = DONE;
                     end
                  end
               end else begin
                  pcnt_d = pcnt_q + PCNT_ONE;
               end
            end
            PAUSE: begin
               if (toggle) begin
                  state_d = RUN;
               end else begin
                  state_d = PAUSE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, count and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= {WIDTH{1'b0}};
         reload_q  <= {WIDTH{1'b0}};
         pcnt_q    <= {PW{1'b0}};
         running_q <= 1'b0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         reload_q  <= reload_d;
         pcnt_q    <= pcnt_d;
         running_q <= (state_d == RUN);
         expired_q <= expired_d;
         done_q    <= (state_d == DONE);
      end
   end

   assign timer   = timer_q;
   assign running = running_q;
   assign expired = expired_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (prescale 1 and 2) driven with directed and
// random stimulus, compared against a cycle-level behavioural model and fixed expectations.
`timescale 1ns/1ps

module tb_countdown_timer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   typedef struct packed {
      int count;
      int reload;
      int elapsed;
      int mode;
      int exp;
   } model_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic       toggle = 1'b0;
   logic       auto_reload = 1'b0;

   logic [3:0] timer_a, timer_b;
   logic       running_a, running_b, expired_a, expired_b, done_a, done_b;

   int     n_tests = 0;
   int     n_fail  = 0;
   model_t ma, mb;

   countdown_timer #(.WIDTH(4), .PRESCALE(1)) u_dut_a (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .toggle(toggle), .auto_reload(auto_reload),
      .timer(timer_a), .running(running_a), .expired(expired_a), .done(done_a)
   );

   countdown_timer #(.WIDTH(4), .PRESCALE(2)) u_dut_b (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .toggle(toggle), .auto_reload(auto_reload),
      .timer(timer_b), .running(running_b), .expired(expired_b), .done(done_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the timer as described behaviourally.
   task automatic model_step(input model_t mi, input int ps, input bit ld, input int lv,
                             input bit tg, input bit ar, output model_t mo);
      mo     = mi;
      mo.exp = 0;
      if (ld) begin
         mo.count   = lv & 15;
         mo.reload  = lv & 15;
         mo.elapsed = 0;
         mo.mode    = M_IDLE;
      end else if (mi.mode == M_IDLE) begin
         if (tg && mi.count != 0) mo.mode = M_RUN;
      end else if (mi.mode == M_PAUSE) begin
         if (tg) mo.mode = M_RUN;
      end else if (mi.mode == M_RUN) begin
         if (tg) begin
            mo.mode = M_PAUSE;
         end else if (mi.elapsed + 1 < ps) begin
            mo.elapsed = mi.elapsed + 1;
         end else begin
            mo.elapsed = 0;
            if (mi.count > 1) begin
               mo.count = mi.count - 1;
            end else begin
               mo.exp = 1;
               if (ar) begin
                  mo.count = mi.reload;
               end else begin
                  mo.count = 0;
                  mo.mode  = M_DONE;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check("a_timer",   int'(timer_a),   ma.count);
      check("a_running", int'(running_a), int'(ma.mode == M_RUN));
      check("a_expired", int'(expired_a), ma.exp);
      check("a_done",    int'(done_a),    int'(ma.mode == M_DONE));
      check("b_timer",   int'(timer_b),   mb.count);
      check("b_running", int'(running_b), int'(mb.mode == M_RUN));
      check("b_expired", int'(expired_b), mb.exp);
      check("b_done",    int'(done_b),    int'(mb.mode == M_DONE));
   endtask

   task automatic cycle(input bit ld, input int lv, input bit tg, input bit ar);
      @(negedge clk);
      load        = ld;
      load_value  = 4'(lv);
      toggle      = tg;
      auto_reload = ar;
      @(posedge clk);
      model_step(ma, 1, ld, lv, tg, ar, ma);
      model_step(mb, 2, ld, lv, tg, ar, mb);
      #1;
      compare_all();
      load   = 1'b0;
      toggle = 1'b0;
   endtask

   // Assert reset between edges and expect every output to clear before the next edge.
   task automatic apply_reset();
      #1;
      reset = 1'b1;
      #1;
      check("rst_a_timer",   int'(timer_a),   0);
      check("rst_a_running", int'(running_a), 0);
      check("rst_a_expired", int'(expired_a), 0);
      check("rst_a_done",    int'(done_a),    0);
      check("rst_b_timer",   int'(timer_b),   0);
      check("rst_b_running", int'(running_b), 0);
      check("rst_b_expired", int'(expired_b), 0);
      check("rst_b_done",    int'(done_b),    0);
      ma = '0;
      mb = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int seq_b[7] = '{3, 3, 2, 2, 1, 1, 0};
      bit ar_lvl;

      ma = '0;
      mb = '0;
      #1;
      check("init_timer",   int'(timer_a), 0);
      check("init_running", int'(running_b), 0);
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a count, then a toggle that must be ignored.
      cycle(1'b1, 5, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0);
      check("midrun_a_timer", int'(timer_a), 3);
      apply_reset();
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("post_rst_idle", int'(running_a), 0);

      // Basic countdown on the prescale-2 instance.
      cycle(1'b1, 3, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("basic_b_t0", int'(timer_b), seq_b[0]);
      for (int i = 1; i < 7; i++) begin
         cycle(1'b0, 0, 1'b0, 1'b0);
         check("basic_b_timer", int'(timer_b), seq_b[i]);
         check("basic_b_expired", int'(expired_b), int'(i == 6));
      end
      check("basic_b_done", int'(done_b), 1);
      cycle(1'b0, 0, 1'b0, 1'b0);
      check("basic_b_exp_drop", int'(expired_b), 0);

      // Pause and resume on the prescale-1 instance.
      cycle(1'b1, 9, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 0, 1'b0, 1'b0);
         check("pause_a_hold", int'(timer_a), 6);
      end
      cycle(1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0, 1'b0);
      check("resume_a_done", int'(done_a), 1);

      // Auto-reload from 2.
      cycle(1'b1, 2, 1'b0, 1'b1);
      cycle(1'b0, 0, 1'b1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 0, 1'b0, 1'b1);
         check("reload_a_no_done", int'(done_a), 0);
         check("reload_a_timer", int'(timer_a), (i % 2 == 0) ? 2 : 1);
      end

      // Edge cases: stop reloading, load in DONE, load 0, load with toggle.
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
      check("edge_a_done", int'(done_a), 1);
      cycle(1'b1, 4, 1'b0, 1'b0);
      check("load_in_done_clr", int'(done_a), 0);
      check("load_in_done_val", int'(timer_a), 4);
      cycle(1'b1, 0, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("zero_toggle_idle", int'(running_a), 0);
      cycle(1'b1, 7, 1'b1, 1'b0);
      check("load_tog_idle", int'(running_a), 0);
      check("load_tog_val", int'(timer_a), 7);

      // Toggle landing on the terminal tick pauses instead of expiring.
      cycle(1'b1, 1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("term_tog_timer", int'(timer_a), 1);
      check("term_tog_noexp", int'(expired_a), 0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0);
      check("term_tog_exp", int'(expired_a), 1);
      check("term_tog_done", int'(done_a), 1);

      // Random traffic.
      ar_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) ar_lvl = ~ar_lvl;
         if ($urandom_range(0, 599) == 0) begin
            apply_reset();
         end else begin
            cycle($urandom_range(0, 19) == 0,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                  $urandom_range(0, 5) == 0, ar_lvl);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
